// File: rtl/eth_st_frame_checker.sv
// Avalon-ST framing checker: validates sop/eop framing and frame length, repairs
// malformed frames by truncation or dropping, and keeps saturating statistics.
module eth_st_frame_checker #(
  parameter int MAX_WORDS = 380,
  parameter int MIN_BYTES = 60,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 in_ready,
  input  logic                 in_valid,
  input  logic [35:0]          in_data,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [31:0]          out_data,
  output logic                 out_sop,
  output logic                 out_eop,
  output logic [1:0]           out_empty,
  output logic                 out_error,
  input  logic                 cnt_clear,
  output logic [CNT_WIDTH-1:0] frame_count,
  output logic [CNT_WIDTH-1:0] error_count,
  output logic [CNT_WIDTH-1:0] drop_count
);

  typedef enum logic [1:0] {S_IDLE, S_FRAME, S_DROP} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [9:0]           r_wcnt;
  logic [9:0]           w_wcnt_nxt;
  logic [9:0]           w_wcnt_inc;
  logic [9:0]           w_beats;
  logic [15:0]          w_len;
  logic                 w_runt;
  logic                 w_at_max;
  logic                 w_accept;
  logic                 w_fwd;
  logic                 w_drop;
  logic                 w_sop;
  logic                 w_eop;
  logic [1:0]           w_empty;
  logic [31:0]          w_payload;
  logic                 w_o_sop;
  logic                 w_o_eop;
  logic [1:0]           w_o_empty;
  logic                 w_o_error;
  logic                 r_out_valid;
  logic [31:0]          r_out_data;
  logic                 r_out_sop;
  logic                 r_out_eop;
  logic [1:0]           r_out_empty;
  logic                 r_out_error;
  logic [CNT_WIDTH-1:0] r_frame_count;
  logic [CNT_WIDTH-1:0] r_error_count;
  logic [CNT_WIDTH-1:0] r_drop_count;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  assign w_payload = in_data[31:0];
  assign w_sop     = in_data[32];
  assign w_eop     = in_data[33];
  assign w_empty   = in_data[35:34];

  assign in_ready  = !r_out_valid || out_ready;
  assign w_accept  = in_valid && in_ready;

  // A frame-opening beat is the first beat, so its length counts from one.
  assign w_wcnt_inc = r_wcnt + 10'd1;
  assign w_beats    = (r_state == S_FRAME) ? w_wcnt_inc : 10'd1;
  assign w_len      = {4'b0000, w_beats, 2'b00} - {14'd0, w_empty};
  assign w_runt     = (w_len < 16'(MIN_BYTES));
  assign w_at_max   = (w_wcnt_inc == 10'(MAX_WORDS));

  always_comb begin
    w_state_nxt = r_state;
    w_wcnt_nxt  = r_wcnt;
    w_fwd       = 1'b0;
    w_drop      = 1'b0;
    w_o_sop     = w_sop;
    w_o_eop     = 1'b0;
    w_o_empty   = 2'b00;
    w_o_error   = 1'b0;
    if (w_accept) begin
      case (r_state)
        S_FRAME: begin
          w_fwd = 1'b1;
          if (w_sop) begin
            // New sop inside a frame closes the old frame as errored.
            w_o_sop     = 1'b0;
            w_o_eop     = 1'b1;
            w_o_error   = 1'b1;
            w_state_nxt = S_DROP;
            w_wcnt_nxt  = 10'd0;
          end else if (w_eop) begin
            w_o_eop     = 1'b1;
            w_o_empty   = w_empty;
            w_o_error   = w_runt;
            w_state_nxt = S_IDLE;
            w_wcnt_nxt  = 10'd0;
          end else if (w_at_max) begin
            w_o_eop     = 1'b1;
            w_o_error   = 1'b1;
            w_state_nxt = S_DROP;
            w_wcnt_nxt  = 10'd0;
          end else begin
            w_wcnt_nxt  = w_wcnt_inc;
          end
        end
        default: begin
          if (w_sop) begin
            w_fwd = 1'b1;
            if (w_eop) begin
              w_o_eop     = 1'b1;
              w_o_empty   = w_empty;
              w_o_error   = w_runt;
              w_state_nxt = S_IDLE;
              w_wcnt_nxt  = 10'd0;
            end else begin
              w_state_nxt = S_FRAME;
              w_wcnt_nxt  = 10'd1;
            end
          end else begin
            w_drop = 1'b1;
            if (r_state == S_DROP && w_eop) begin
              w_state_nxt = S_IDLE;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_wcnt  <= 10'd0;
    end else begin
      r_state <= w_state_nxt;
      r_wcnt  <= w_wcnt_nxt;
    end
  end

  // Output stage: load on forward, retire on handshake, hold while stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= 32'd0;
      r_out_sop   <= 1'b0;
      r_out_eop   <= 1'b0;
      r_out_empty <= 2'b00;
      r_out_error <= 1'b0;
    end else if (w_fwd) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_payload;
      r_out_sop   <= w_o_sop;
      r_out_eop   <= w_o_eop;
      r_out_empty <= w_o_empty;
      r_out_error <= w_o_error;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_frame_count <= '0;
      r_error_count <= '0;
      r_drop_count  <= '0;
    end else if (cnt_clear) begin
      r_frame_count <= '0;
      r_error_count <= '0;
      r_drop_count  <= '0;
    end else begin
      if (w_fwd && w_o_eop) begin
        r_frame_count <= sat_inc(r_frame_count);
      end
      if (w_fwd && w_o_error) begin
        r_error_count <= sat_inc(r_error_count);
      end
      if (w_drop) begin
        r_drop_count <= sat_inc(r_drop_count);
      end
    end
  end

  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;
  assign out_sop     = r_out_sop;
  assign out_eop     = r_out_eop;
  assign out_empty   = r_out_empty;
  assign out_error   = r_out_error;
  assign frame_count = r_frame_count;
  assign error_count = r_error_count;
  assign drop_count  = r_drop_count;

endmodule

// File: tb/tb_eth_st_frame_checker.sv
// Directed bench for eth_st_frame_checker: three instances (default, short max
// frame, narrow counters) share one stimulus stream.
`timescale 1ns/1ps
module tb_eth_st_frame_checker;

  typedef struct packed {
    logic        err;
    logic [1:0]  m;
    logic        e;
    logic        s;
    logic [31:0] d;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [35:0] in_data = '0;
  logic        out_ready = 1'b1;
  logic        cnt_clear = 1'b0;

  logic        in_ready_a, out_valid_a, out_sop_a, out_eop_a, out_error_a;
  logic [31:0] out_data_a;
  logic [1:0]  out_empty_a;
  logic [15:0] frame_count_a, error_count_a, drop_count_a;

  logic        in_ready_b, out_valid_b, out_sop_b, out_eop_b, out_error_b;
  logic [31:0] out_data_b;
  logic [1:0]  out_empty_b;
  logic [15:0] frame_count_b, error_count_b, drop_count_b;

  logic        in_ready_c, out_valid_c, out_sop_c, out_eop_c, out_error_c;
  logic [31:0] out_data_c;
  logic [1:0]  out_empty_c;
  logic [1:0]  frame_count_c, error_count_c, drop_count_c;

  eth_st_frame_checker dut_a (
    .clk(clk), .reset(reset), .in_ready(in_ready_a), .in_valid(in_valid),
    .in_data(in_data), .out_ready(out_ready), .out_valid(out_valid_a),
    .out_data(out_data_a), .out_sop(out_sop_a), .out_eop(out_eop_a),
    .out_empty(out_empty_a), .out_error(out_error_a), .cnt_clear(cnt_clear),
    .frame_count(frame_count_a), .error_count(error_count_a), .drop_count(drop_count_a)
  );

  eth_st_frame_checker #(.MAX_WORDS(8), .MIN_BYTES(16)) dut_b (
    .clk(clk), .reset(reset), .in_ready(in_ready_b), .in_valid(in_valid),
    .in_data(in_data), .out_ready(out_ready), .out_valid(out_valid_b),
    .out_data(out_data_b), .out_sop(out_sop_b), .out_eop(out_eop_b),
    .out_empty(out_empty_b), .out_error(out_error_b), .cnt_clear(cnt_clear),
    .frame_count(frame_count_b), .error_count(error_count_b), .drop_count(drop_count_b)
  );

  eth_st_frame_checker #(.CNT_WIDTH(2)) dut_c (
    .clk(clk), .reset(reset), .in_ready(in_ready_c), .in_valid(in_valid),
    .in_data(in_data), .out_ready(out_ready), .out_valid(out_valid_c),
    .out_data(out_data_c), .out_sop(out_sop_c), .out_eop(out_eop_c),
    .out_empty(out_empty_c), .out_error(out_error_c), .cnt_clear(cnt_clear),
    .frame_count(frame_count_c), .error_count(error_count_c), .drop_count(drop_count_c)
  );

  int ntests = 0;
  int nfail  = 0;
  int cyc    = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic beat_t bt(input logic err, input logic [1:0] m, input logic e,
                               input logic s, input logic [31:0] d);
    return {err, m, e, s, d};
  endfunction

  // out_ready pattern 1,0,0,1 then high, applied once per cycle after the edge
  logic       bp_en  = 1'b0;
  int         bp_idx = 0;
  logic [3:0] bp_pat = 4'b1001;
  always @(posedge clk) begin
    #2;
    if (bp_en && bp_idx < 4) begin
      out_ready = bp_pat[bp_idx];
      bp_idx++;
    end else begin
      out_ready = 1'b1;
    end
  end

  beat_t qa[$];
  beat_t qb[$];
  logic  stall_a = 1'b0;
  beat_t held_a;
  always @(negedge clk) begin
    if (stall_a) begin
      chk("hold_a", {out_error_a, out_empty_a, out_eop_a, out_sop_a, out_data_a}, held_a);
    end
    stall_a = out_valid_a && !out_ready;
    held_a  = {out_error_a, out_empty_a, out_eop_a, out_sop_a, out_data_a};
    if (out_valid_a && out_ready) qa.push_back(held_a);
    if (out_valid_b && out_ready)
      qb.push_back({out_error_b, out_empty_b, out_eop_b, out_sop_b, out_data_b});
  end

  task automatic send(input logic [31:0] d, input logic s, input logic e, input logic [1:0] m);
    int   n;
    logic acc;
    n   = 0;
    acc = 1'b0;
    in_valid = 1'b1;
    in_data  = {m, e, s, d};
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready_a;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) chk("send_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    qa.delete();
    qb.delete();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t0;
    #12;
    chk("rst_valid", out_valid_a, 0);
    chk("rst_data", out_data_a, 0);
    chk("rst_ctl", {out_sop_a, out_eop_a, out_empty_a, out_error_a}, 0);
    chk("rst_cnts", {frame_count_a, error_count_a, drop_count_a}, 0);
    chk("rst_ready", in_ready_a, 1);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // legal 16-beat frame, 62 bytes
    t0 = cyc;
    for (int i = 0; i < 16; i++)
      send(32'hA000_0000 + i, i == 0, i == 15, (i == 15) ? 2'd2 : 2'd0);
    chk("t1_cycles", cyc - t0, 16);
    idle(3);
    chk("t1_size", qa.size(), 16);
    for (int i = 0; i < 16; i++)
      if (i < qa.size())
        chk("t1_beat", qa[i], bt(1'b0, (i == 15) ? 2'd2 : 2'd0, i == 15, i == 0, 32'hA000_0000 + i));
    chk("t1_frames", frame_count_a, 1);
    chk("t1_errors", error_count_a, 0);
    chk("t1_drops", drop_count_a, 0);

    // runt: 4 beats, 16 bytes
    do_reset();
    for (int i = 0; i < 4; i++) send(32'hB000_0000 + i, i == 0, i == 3, 2'd0);
    idle(3);
    chk("t2_size", qa.size(), 4);
    if (qa.size() == 4) chk("t2_last", qa[3], bt(1'b1, 2'd0, 1'b1, 1'b0, 32'hB000_0003));
    chk("t2_errors", error_count_a, 1);
    chk("t2_frames", frame_count_a, 1);

    // oversize on MAX_WORDS=8 instance, then clean frames
    do_reset();
    for (int i = 0; i < 12; i++) send(32'hC000_0000 + i, i == 0, i == 11, 2'd0);
    idle(3);
    chk("t3_size", qb.size(), 8);
    for (int i = 0; i < 8; i++)
      if (i < qb.size())
        chk("t3_beat", qb[i], bt(i == 7, 2'd0, i == 7, i == 0, 32'hC000_0000 + i));
    chk("t3_drops", drop_count_b, 4);
    chk("t3_errors", error_count_b, 1);
    for (int i = 0; i < 6; i++) send(32'hD000_0000 + i, i == 0, i == 5, 2'd0);
    for (int i = 0; i < 8; i++) send(32'hE000_0000 + i, i == 0, i == 7, (i == 7) ? 2'd1 : 2'd0);
    idle(3);
    chk("t3_size2", qb.size(), 22);
    if (qb.size() == 22) begin
      chk("t3_legal", qb[13], bt(1'b0, 2'd0, 1'b1, 1'b0, 32'hD000_0005));
      chk("t3_atmax", qb[21], bt(1'b0, 2'd1, 1'b1, 1'b0, 32'hE000_0007));
    end
    chk("t3_cnts", {frame_count_b, error_count_b, drop_count_b}, {16'd3, 16'd1, 16'd4});

    // missing eop: new sop closes the old frame, rest of new frame dropped
    do_reset();
    for (int i = 0; i < 5; i++) send(32'hF000_0000 + i, i == 0, 1'b0, 2'd0);
    send(32'h1111_0000, 1'b1, 1'b0, 2'd3);
    send(32'h1111_0001, 1'b0, 1'b0, 2'd0);
    send(32'h1111_0002, 1'b0, 1'b1, 2'd1);
    idle(3);
    chk("t4_size", qa.size(), 6);
    if (qa.size() == 6) begin
      chk("t4_plain", qa[4], bt(1'b0, 2'd0, 1'b0, 1'b0, 32'hF000_0004));
      chk("t4_cut", qa[5], bt(1'b1, 2'd0, 1'b1, 1'b0, 32'h1111_0000));
    end
    chk("t4_cnts", {frame_count_a, error_count_a, drop_count_a}, {16'd1, 16'd1, 16'd2});

    // orphans, then a 4-beat frame under backpressure
    do_reset();
    for (int i = 0; i < 3; i++) send(32'h2222_0000 + i, 1'b0, i == 2, 2'd0);
    chk("t5_drops", drop_count_a, 3);
    chk("t5_novalid", out_valid_a, 0);
    t0 = cyc;
    bp_en  = 1'b1;
    bp_idx = 0;
    for (int i = 0; i < 4; i++) send(32'h3333_0000 + i, i == 0, i == 3, 2'd0);
    bp_en = 1'b0;
    chk("t5_cycles", cyc - t0, 6);
    idle(3);
    chk("t5_size", qa.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < qa.size())
        chk("t5_beat", qa[i], bt(i == 3, 2'd0, i == 3, i == 0, 32'h3333_0000 + i));

    // reset mid-frame
    do_reset();
    for (int i = 0; i < 3; i++) send(32'h4444_0000 + i, i == 0, 1'b0, 2'd0);
    chk("t6_prevalid", out_valid_a, 1);
    reset = 1'b1;
    #1;
    chk("t6_async_valid", out_valid_a, 0);
    chk("t6_async_data", out_data_a, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    qa.delete();
    send(32'h5555_0000, 1'b0, 1'b0, 2'd0);
    send(32'h5555_0001, 1'b0, 1'b1, 2'd0);
    idle(2);
    chk("t6_orphan_out", qa.size(), 0);
    chk("t6_orphan_drops", drop_count_a, 2);

    // saturation on 2-bit counters
    for (int i = 0; i < 3; i++) send(32'h6666_0000 + i, 1'b1, 1'b1, 2'd0);
    chk("t6_frames3", frame_count_c, 3);
    send(32'h6666_0003, 1'b1, 1'b1, 2'd0);
    chk("t6_sat_frames", frame_count_c, 3);
    chk("t6_sat_errors", error_count_c, 3);
    cnt_clear = 1'b1;
    send(32'h6666_0004, 1'b1, 1'b1, 2'd0);
    cnt_clear = 1'b0;
    chk("t6_clear", {frame_count_c, error_count_c, drop_count_c}, 0);
    send(32'h6666_0005, 1'b1, 1'b1, 2'd0);
    chk("t6_after_clear", frame_count_c, 1);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/eth_st_frame_checker.md
# eth_st_frame_checker

Avalon-ST framing checker that sits directly downstream of the Ethernet timing-adapter FIFO. It consumes the FIFO's 36-bit packed stream, validates sop/eop framing and frame length, and repairs malformed frames so the MAC-side consumer always sees well-formed packets. Malformed frames are either truncated or dropped, with an error flag on the closing beat and saturating statistics counters. It adds one registered output stage and sustains full throughput.

## Interface
Parameters:
- MAX_WORDS, 380: maximum beats per frame (380 x 4 = 1520 bytes).
- MIN_BYTES, 60: minimum legal frame length in bytes.
- CNT_WIDTH, 16: width of the statistics counters.

Ports:
- clk  in  1  single clock for all logic.
- reset  in  1  asynchronous, active-high reset.
- in_ready  out  1  sink ready; equals !out_valid || out_ready (combinational).
- in_valid  in  1  source beat valid.
- in_data  in  36  packed beat: [31:0] payload, [32] sop, [33] eop, [35:34] empty.
- out_ready  in  1  downstream ready (ready latency 0).
- out_valid  out  1  output beat valid, registered.
- out_data  out  32  payload, registered.
- out_sop  out  1  start of packet, registered.
- out_eop  out  1  end of packet, registered.
- out_empty  out  2  empty bytes on the eop beat, registered.
- out_error  out  1  error flag, only meaningful on the eop beat.
- cnt_clear  in  1  synchronous clear of all counters.
- frame_count  out  CNT_WIDTH  forwarded eop beats; saturating.
- error_count  out  CNT_WIDTH  forwarded beats with out_error=1; saturating.
- drop_count  out  CNT_WIDTH  accepted beats that were discarded; saturating.

## Operation
- A beat is accepted when in_valid && in_ready. Every accepted beat is either forwarded (it loads the output register) or dropped (it only updates state and counters).
- Word counter wcnt (10 bits) counts forwarded beats of the current frame. Byte length at eop = 4*wcnt - empty, computed in 16 bits.
- States:
  - IDLE:
    - Beat without sop: drop; drop_count++.
    - sop beat: forward; wcnt=1; go to FRAME, unless eop=1.
    - sop && eop beat: single-beat frame; runt check applies; stay in IDLE.
  - FRAME:
    - Plain beat: forward; wcnt++.
    - eop beat: forward; out_error = (length < MIN_BYTES); go to IDLE.
    - sop beat (unterminated previous frame): forward with sop=0, eop=1, empty=0, error=1; go to DROP.
    - Non-eop beat that makes wcnt reach MAX_WORDS: forward with eop=1, empty=0, error=1; go to DROP.
    - Beat with eop=1 arriving exactly at MAX_WORDS: legal; no truncation.
  - DROP:
    - Plain beat: drop; drop_count++.
    - eop beat: drop; drop_count++; go to IDLE.
    - sop beat: treated exactly as the IDLE sop case (forwarded; starts a new frame).
- Forced fields:
  - Forwarded beats that are not eop always carry out_empty=0 and out_error=0.
  - out_empty passes through only on a natural eop.
- Counters:
  - frame_count increments on each forwarded beat with eop=1.
  - error_count increments on each forwarded beat with error=1.
  - All counters saturate at all-ones.
  - cnt_clear has priority over increments in the same cycle.
- Reset: state=IDLE, wcnt=0, out_valid=0, out_data/out_sop/out_eop/out_empty/out_error=0, all counters=0.
- Reset asserted mid-frame abandons the frame. Subsequent beats without sop are dropped as orphans.

## Timing
- Latency: a beat accepted at edge N appears on out_* after edge N; one cycle.
- Output register update:
  - Loads whenever a forwarded beat is accepted.
  - Otherwise clears out_valid when out_ready && out_valid.
  - Holds all out_* stable while out_valid && !out_ready.
- Throughput: one beat per cycle with out_ready held high.
- Dropped beats are accepted at full rate whenever in_ready=1 and never assert out_valid.
- Counters update on the same edge as the accepting/forwarding event and are registered.

## Test plan
- Legal frame: 16 beats, sop on beat 0, eop+empty=2 on beat 15, out_ready=1. Expect 16 outputs at 1/cycle, length 62, out_error=0, frame_count=1.
- Runt frame: 4 beats, empty=0 (16 bytes). Expect forwarded with out_error=1 on beat 3, error_count=1.
- Oversize frame: MAX_WORDS=8, send 12 beats. Expect 8 forwarded, beat 7 eop=1/error=1, 4 dropped, drop_count=4, then the next legal frame passes clean.
- Missing eop: 5-beat frame with no eop, then a new sop frame of 3 beats. Expect the new sop beat emitted as eop/error; its remaining 2 beats dropped, including its eop.
- Orphans and backpressure: 3 beats without sop, then a legal 4-beat frame with out_ready toggling 1,0,0,1. Expect drop_count=3, out_* held while stalled, data order intact.
- Reset mid-frame, then counter saturation with CNT_WIDTH=2. Expect out_valid=0 immediately; post-reset continuation beats dropped; frame_count sticks at 3; cnt_clear returns it to 0.
